call_return_ctrl: RTL and testbench

Call/return sequencer in the IF stage and the initiator side of the return-address stack: it accepts decoded CALL/RET events, issues one-cycle push/pop strobes to the stack, and redirects the PC. It also tracks stack depth and latches a sticky fault on overflow, underflow or conflicting requests. It sits between the decoder/UC and the stack. The PC mux consumes `redirect_valid`/`redirect_pc`.

---
 rtl/call_ret_pkg.sv | 19 +
 rtl/call_ret_depth_tracker.sv | 31 +++
 rtl/call_return_ctrl.sv | 161 ++++++++++++++++
 tb/tb_call_return_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/call_ret_pkg.sv
// Shared types and constants for the call/return sequencer and its depth tracker.
package call_ret_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_POP   = 3'd2,
    S_REDIR = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_OVF      = 2'b01;
  localparam logic [1:0] FAULT_UNF      = 2'b10;
  localparam logic [1:0] FAULT_CONFLICT = 2'b11;

  localparam int unsigned RET_ADDR_INCR = 4;

endpackage

// File: rtl/call_ret_depth_tracker.sv
// Saturating shadow count of return-address stack occupancy (0..STACK_DEPTH).
module call_ret_depth_tracker #(
  parameter int STACK_DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] r_depth;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
    end else if (i_inc && !i_dec && (r_depth != DEPTH_MAX)) begin
      r_depth <= r_depth + DEPTH_W'(1);
    end else if (i_dec && !i_inc && (r_depth != '0)) begin
      r_depth <= r_depth - DEPTH_W'(1);
    end
  end

  assign o_full  = (r_depth == DEPTH_MAX);
  assign o_empty = (r_depth == '0);

endmodule

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: drives return-stack push/pop strobes and PC redirects.
// Define CALL_RET_DEPTH_CHECK_EN to fault on depth locally instead of trusting the stack's flag.
module call_return_ctrl
  import call_ret_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic                  ret_valid,
  input  logic [ADDR_WIDTH-1:0] call_target,
  input  logic [ADDR_WIDTH-1:0] pc_current,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  push_en,
  output logic [ADDR_WIDTH-1:0] push_data,
  output logic                  pop_en,
  input  logic [ADDR_WIDTH-1:0] pop_data,
  input  logic                  stack_fault_in,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_PUSH  = S_PUSH;
  localparam logic [2:0] ST_POP   = S_POP;
  localparam logic [2:0] ST_REDIR = S_REDIR;
  localparam logic [2:0] ST_FAULT = S_FAULT;

  logic [2:0]            r_state;
  logic                  r_push_en;
  logic                  r_pop_en;
  logic                  r_call_redir;
  logic [ADDR_WIDTH-1:0] r_push_data;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic                  r_fault;
  logic [1:0]            r_fault_code;

  logic                  w_call_blocked;
  logic                  w_ret_blocked;
  logic                  w_push_fault;
  logic                  w_redir_abort;
  logic [ADDR_WIDTH-1:0] w_ret_addr;

  assign w_ret_addr = pc_current + ADDR_WIDTH'(RET_ADDR_INCR);

`ifdef CALL_RET_DEPTH_CHECK_EN
  logic w_full;
  logic w_empty;
  logic w_unused_fault_in;

  call_ret_depth_tracker #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_depth (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_push_en),
    .i_dec   (r_pop_en),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_call_blocked    = w_full;
  assign w_ret_blocked     = w_empty;
  assign w_push_fault      = 1'b0;
  assign w_redir_abort     = 1'b0;
  assign w_unused_fault_in = stack_fault_in;
`else
  logic                           r_after_push;
  logic [$clog2(STACK_DEPTH+1):0] w_unused_depth;

  // The stack's flag is registered, so it reflects a push one cycle after push_en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_after_push <= 1'b0;
    else       r_after_push <= (r_state == ST_PUSH);
  end

  assign w_call_blocked = 1'b0;
  assign w_ret_blocked  = 1'b0;
  assign w_push_fault   = r_after_push & stack_fault_in;
  assign w_redir_abort  = stack_fault_in;
  assign w_unused_depth = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_push_en     <= 1'b0;
      r_pop_en      <= 1'b0;
      r_call_redir  <= 1'b0;
      r_push_data   <= '0;
      r_redirect_pc <= '0;
      r_fault       <= 1'b0;
      r_fault_code  <= FAULT_NONE;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge state; strobes default low.
      r_push_en    <= 1'b0;
      r_pop_en     <= 1'b0;
      r_call_redir <= 1'b0;
      if (w_push_fault) begin
        r_state      <= ST_FAULT;
        r_fault      <= 1'b1;
        r_fault_code <= FAULT_OVF;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (call_valid && ret_valid) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_CONFLICT;
            end else if (call_valid && w_call_blocked) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_OVF;
            end else if (call_valid) begin
              r_state       <= ST_PUSH;
              r_push_en     <= 1'b1;
              r_call_redir  <= 1'b1;
              r_push_data   <= w_ret_addr;
              r_redirect_pc <= call_target;
            end else if (ret_valid && w_ret_blocked) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_UNF;
            end else if (ret_valid) begin
              r_state  <= ST_POP;
              r_pop_en <= 1'b1;
            end
          end
          ST_PUSH: r_state <= ST_IDLE;
          ST_POP:  r_state <= ST_REDIR;
          ST_REDIR: begin
            if (w_redir_abort) begin
              r_state      <= ST_FAULT;
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_UNF;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_FAULT: r_state <= ST_FAULT;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // pop_data is already registered inside the stack, so REDIR forwards it directly.
  assign busy           = (r_state != ST_IDLE);
  assign redirect_valid = r_call_redir | ((r_state == ST_REDIR) & ~w_redir_abort);
  assign redirect_pc    = (r_state == ST_REDIR) ? pop_data : r_redirect_pc;
  assign push_en        = r_push_en;
  assign push_data      = r_push_data;
  assign pop_en         = r_pop_en;
  assign fault          = r_fault;
  assign fault_code     = r_fault_code;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a small behavioural return-address stack.
module tb_call_return_ctrl;

  logic        clock;
  logic        reset;
  logic        call_valid;
  logic        ret_valid;
  logic [31:0] call_target;
  logic [31:0] pc_current;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        push_en;
  logic [31:0] push_data;
  logic        pop_en;
  logic [31:0] pop_data;
  logic        stack_fault_in;
  logic        fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad   = 0;

  call_return_ctrl #(
    .ADDR_WIDTH  (32),
    .STACK_DEPTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .call_valid     (call_valid),
    .ret_valid      (ret_valid),
    .call_target    (call_target),
    .pc_current     (pc_current),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .push_en        (push_en),
    .push_data      (push_data),
    .pop_en         (pop_en),
    .pop_data       (pop_data),
    .stack_fault_in (stack_fault_in),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Return-address stack model: registered output, sticky error flag.
  logic [31:0] stk [8];
  int          sp;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sp             <= 0;
      pop_data       <= '0;
      stack_fault_in <= 1'b0;
    end else begin
      if (push_en) begin
        if (sp == 8) stack_fault_in <= 1'b1;
        else begin
          stk[sp] <= push_data;
          sp      <= sp + 1;
        end
      end else if (pop_en) begin
        if (sp == 0) stack_fault_in <= 1'b1;
        else begin
          pop_data <= stk[sp-1];
          sp       <= sp - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Both tasks return 1ns after the sampling edge, i.e. inside cycle N+1.
  task automatic issue_call(input logic [31:0] pc, input logic [31:0] tgt);
    pc_current  = pc;
    call_target = tgt;
    call_valid  = 1'b1;
    step();
    call_valid  = 1'b0;
  endtask

  task automatic issue_ret();
    ret_valid = 1'b1;
    step();
    ret_valid = 1'b0;
  endtask

  task automatic check_ret(input string tag, input logic [31:0] exp_pc);
    issue_ret();
    check({tag, "_pop_en"}, 32'(pop_en), 32'd1);
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    check({tag, "_early_redir"}, 32'(redirect_valid), 32'd0);
    step();
    check({tag, "_redir_valid"}, 32'(redirect_valid), 32'd1);
    check({tag, "_redir_pc"}, redirect_pc, exp_pc);
    check({tag, "_busy2"}, 32'(busy), 32'd1);
    step();
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic saw_redir;
    call_valid  = 1'b0;
    ret_valid   = 1'b0;
    call_target = '0;
    pc_current  = '0;
    reset       = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", {29'd0, push_en, pop_en, redirect_valid}, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    check("rst_push_data", push_data, 32'd0);
    check("rst_fault", {29'd0, fault, fault_code}, 32'd0);
    reset = 1'b0;
    step();

    // Basic CALL then RET
    issue_call(32'h100, 32'h400);
    check("call_push_en", 32'(push_en), 32'd1);
    check("call_push_data", push_data, 32'h104);
    check("call_redir_valid", 32'(redirect_valid), 32'd1);
    check("call_redir_pc", redirect_pc, 32'h400);
    check("call_busy", 32'(busy), 32'd1);
    step();
    check("call_done", {29'd0, busy, push_en, redirect_valid}, 32'd0);
    check_ret("ret1", 32'h104);

    // Nested CALLs unwind in reverse order
    issue_call(32'h10, 32'h1000);
    check("nest_push0", push_data, 32'h14);
    step();
    check("nest_busy0", 32'(busy), 32'd0);
    issue_call(32'h20, 32'h2000);
    check("nest_push1", push_data, 32'h24);
    step();
    issue_call(32'h30, 32'h3000);
    check("nest_push2", push_data, 32'h34);
    step();
    check_ret("nret0", 32'h34);
    check_ret("nret1", 32'h24);
    check_ret("nret2", 32'h14);

    // Return-address wrap is not a fault
    issue_call(32'hFFFF_FFFC, 32'h40);
    check("wrap_push_data", push_data, 32'h0);
    check("wrap_redir_pc", redirect_pc, 32'h40);
    step();
    step();
    check("wrap_no_fault", {30'd0, fault_code}, 32'd0);
    check("wrap_fault", 32'(fault), 32'd0);
    check_ret("wrap_ret", 32'h0);

    // Reset asserted during POP aborts without a redirect
    issue_call(32'h200, 32'h800);
    step();
    issue_ret();
    check("abort_pop_en", 32'(pop_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort_async", {30'd0, busy, pop_en}, 32'd0);
    saw_redir = 1'b0;
    step();
    saw_redir |= redirect_valid;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw_redir |= redirect_valid;
    end
    check("abort_no_redir", 32'(saw_redir), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // CALL+RET conflict
    call_valid = 1'b1;
    ret_valid  = 1'b1;
    step();
    call_valid = 1'b0;
    ret_valid  = 1'b0;
    check("conf_strobes", {29'd0, push_en, pop_en, redirect_valid}, 32'd0);
    check("conf_fault", {29'd0, fault, fault_code}, 32'h7);
    check("conf_busy", 32'(busy), 32'd1);
    step();
    issue_call(32'h500, 32'h600);
    check("conf_ignored", {29'd0, push_en, redirect_valid, busy}, 32'd1);
    check("conf_sticky", {30'd0, fault_code}, 32'd3);

    // Reset clears the fault, and a CALL works again
    do_reset();
    check("post_rst_outs", {27'd0, busy, push_en, pop_en, redirect_valid, fault}, 32'd0);
    check("post_rst_code", {30'd0, fault_code}, 32'd0);
    issue_call(32'h700, 32'h900);
    check("post_rst_push", {30'd0, push_en, redirect_valid}, 32'd3);
    check("post_rst_data", push_data, 32'h704);
    check("post_rst_target", redirect_pc, 32'h900);
    do_reset();

`ifdef CALL_RET_DEPTH_CHECK_EN
    for (int i = 0; i < 8; i++) begin
      issue_call(32'(i * 16), 32'(32'h1000 + i));
      check("fill_push", 32'(push_en), 32'd1);
      step();
    end
    issue_call(32'h90, 32'h2000);
    check("ovf_no_push", {30'd0, push_en, redirect_valid}, 32'd0);
    check("ovf_fault", {29'd0, fault, fault_code}, 32'h5);
    step();
    issue_ret();
    check("ovf_ret_ignored", 32'(pop_en), 32'd0);
    step();
    check("ovf_no_redir", 32'(redirect_valid), 32'd0);
    check("ovf_sticky", {30'd0, fault_code}, 32'd1);
    do_reset();
    issue_ret();
    check("unf_no_pop", 32'(pop_en), 32'd0);
    check("unf_fault", {29'd0, fault, fault_code}, 32'h6);
`else
    issue_ret();
    check("unf_pop_en", 32'(pop_en), 32'd1);
    step();
    check("unf_no_redir", 32'(redirect_valid), 32'd0);
    check("unf_busy", 32'(busy), 32'd1);
    step();
    check("unf_fault", {29'd0, fault, fault_code}, 32'h6);
    check("unf_stuck", 32'(busy), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
